// File: rtl/pll_reconfig_pkg.sv
// pll_reconfig_pkg: sequencer state encoding and MD-port opcodes for pll_reconfig_ctrl.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

package pll_reconfig_pkg;

  typedef enum logic [3:0] {
    ST_INIT_RST  = 4'd0,
    ST_RST       = 4'd1,
    ST_WAIT_LOCK = 4'd2,
    ST_IDLE      = 4'd3,
    ST_ADDR      = 4'd4,
    ST_GAP1      = 4'd5,
    ST_OP        = 4'd6,
    ST_GAP2      = 4'd7,
    ST_CAPTURE   = 4'd8,
    ST_DONE      = 4'd9
  } pll_state_t;

  localparam logic [1:0] MD_NOP  = 2'b00;
  localparam logic [1:0] MD_ADDR = 2'b11;
  localparam logic [1:0] MD_WR   = 2'b01;
  localparam logic [1:0] MD_RD   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: two-flop synchronizer for the raw PLL lock, async reset to 0.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

`default_nettype wire

// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: PLL MD-port request sequencer with reset/lock handling and retry.
// Rev 1.0 -- define PLL_RECONFIG_READBACK_EN to verify each write by reading it back.
`timescale 1ns/1ps
`default_nettype none

module pll_reconfig_ctrl
  import pll_reconfig_pkg::*;
#(
  parameter int RST_CYCLES   = 8,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int RETRY_MAX    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  input  logic       req_relock,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic       resp_error,
  output logic       busy,
  output logic       locked,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic [1:0] md_opc,
  output logic [7:0] md_wdi,
  input  logic [7:0] md_rdo
);

  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam int LCW = $clog2(LOCK_TIMEOUT + 1);
  localparam int RTW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  localparam logic [RCW-1:0] c_rst_last  = RCW'(RST_CYCLES - 1);
  localparam logic [LCW-1:0] c_lock_last = LCW'(LOCK_TIMEOUT - 1);
  localparam logic [RTW-1:0] c_retry_max = RTW'(RETRY_MAX);

  pll_state_t     r_state;
  logic           r_init;
  logic [RCW-1:0] r_rst_cnt;
  logic [LCW-1:0] r_lock_cnt;
  logic [RTW-1:0] r_retry;
  logic           r_write;
  logic [7:0]     r_addr;
  logic [7:0]     r_wdata;
  logic           r_relock;
  logic           r_pll_rst;
  logic [1:0]     r_md_opc;
  logic [7:0]     r_md_wdi;
  logic           r_resp_valid;
  logic           r_resp_error;
  logic [7:0]     r_resp_rdata;
  logic           r_busy;
  logic           r_ready;
  logic           w_lock_s;
  logic           w_op_read;
`ifdef PLL_RECONFIG_READBACK_EN
  logic           r_rb_phase;
`endif

  pll_lock_sync u_lock_sync (
    .clk     (clk),
    .rst     (reset),
    .i_async (pll_lock),
    .o_sync  (w_lock_s)
  );

`ifdef PLL_RECONFIG_READBACK_EN
  assign w_op_read = ~r_write | r_rb_phase;
`else
  assign w_op_read = ~r_write;
`endif

  // busy/ready are registered: both read 0 while reset is held, then track the IDLE state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_INIT_RST;
      r_init       <= 1'b1;
      r_rst_cnt    <= '0;
      r_lock_cnt   <= '0;
      r_retry      <= '0;
      r_write      <= 1'b0;
      r_addr       <= 8'h00;
      r_wdata      <= 8'h00;
      r_relock     <= 1'b0;
      r_pll_rst    <= 1'b1;
      r_md_opc     <= MD_NOP;
      r_md_wdi     <= 8'h00;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_rdata <= 8'h00;
      r_busy       <= 1'b0;
      r_ready      <= 1'b0;
`ifdef PLL_RECONFIG_READBACK_EN
      r_rb_phase   <= 1'b0;
`endif
    end else begin
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b1;
      r_ready      <= 1'b0;
      case (r_state)
        ST_INIT_RST, ST_RST: begin
          if (r_rst_cnt == c_rst_last) begin
            r_rst_cnt <= '0;
            r_pll_rst <= 1'b0;
            r_state   <= ST_WAIT_LOCK;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (w_lock_s || (r_lock_cnt == c_lock_last)) begin
            r_lock_cnt <= '0;
            if (!w_lock_s && (r_retry < c_retry_max)) begin
              r_retry   <= r_retry + 1'b1;
              r_pll_rst <= 1'b1;
              r_state   <= ST_RST;
            end else if (r_init) begin
              // Power-up has no requester to answer: report failure as a level.
              r_init       <= 1'b0;
              r_resp_error <= ~w_lock_s;
              r_busy       <= 1'b0;
              r_ready      <= 1'b1;
              r_state      <= ST_IDLE;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_error <= ~w_lock_s;
              r_state      <= ST_DONE;
            end
          end else begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_valid) begin
            r_write      <= req_write;
            r_addr       <= req_addr;
            r_wdata      <= req_wdata;
            r_relock     <= req_relock & req_write;
            r_retry      <= '0;
            r_resp_error <= 1'b0;
            r_md_opc     <= MD_ADDR;
            r_md_wdi     <= req_addr;
`ifdef PLL_RECONFIG_READBACK_EN
            r_rb_phase   <= 1'b0;
`endif
            r_state      <= ST_ADDR;
          end else begin
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        ST_ADDR: begin
          r_md_opc <= MD_NOP;
          r_state  <= ST_GAP1;
        end
        ST_GAP1: begin
          if (w_op_read) begin
            r_md_opc <= MD_RD;
          end else begin
            r_md_opc <= MD_WR;
            r_md_wdi <= r_wdata;
          end
          r_state <= ST_OP;
        end
        ST_OP: begin
          r_md_opc <= MD_NOP;
          r_state  <= ST_GAP2;
        end
        ST_GAP2: begin
          if (w_op_read) begin
            r_state <= ST_CAPTURE;
          end else begin
`ifdef PLL_RECONFIG_READBACK_EN
            r_rb_phase <= 1'b1;
            r_md_opc   <= MD_ADDR;
            r_md_wdi   <= r_addr;
            r_state    <= ST_ADDR;
`else
            if (r_relock) begin
              r_pll_rst <= 1'b1;
              r_state   <= ST_RST;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b0;
              r_state      <= ST_DONE;
            end
`endif
          end
        end
        ST_CAPTURE: begin
`ifdef PLL_RECONFIG_READBACK_EN
          if (r_rb_phase) begin
            if (md_rdo != r_wdata) begin
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b1;
              r_state      <= ST_DONE;
            end else if (r_relock) begin
              r_pll_rst <= 1'b1;
              r_state   <= ST_RST;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b0;
              r_state      <= ST_DONE;
            end
          end else begin
            r_resp_rdata <= md_rdo;
            r_resp_valid <= 1'b1;
            r_resp_error <= 1'b0;
            r_state      <= ST_DONE;
          end
`else
          r_resp_rdata <= md_rdo;
          r_resp_valid <= 1'b1;
          r_resp_error <= 1'b0;
          r_state      <= ST_DONE;
`endif
        end
        ST_DONE: begin
          r_resp_error <= 1'b0;
          r_busy       <= 1'b0;
          r_ready      <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_init    <= 1'b1;
          r_rst_cnt <= '0;
          r_pll_rst <= 1'b1;
          r_md_opc  <= MD_NOP;
          r_state   <= ST_INIT_RST;
        end
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign busy       = r_busy;
  assign locked     = w_lock_s & r_ready;
  assign resp_valid = r_resp_valid;
  assign resp_error = r_resp_error;
  assign resp_rdata = r_resp_rdata;
  assign pll_rst    = r_pll_rst;
  assign md_opc     = r_md_opc;
  assign md_wdi     = r_md_wdi;

endmodule

`default_nettype wire

// File: tb/tb_pll_reconfig_ctrl.sv
// tb_pll_reconfig_ctrl: directed self-checking bench for pll_reconfig_ctrl (4/16/2 parameters).
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_pll_reconfig_ctrl;

  localparam int RST_CYCLES   = 4;
  localparam int LOCK_TIMEOUT = 16;
  localparam int RETRY_MAX    = 2;

`ifdef PLL_RECONFIG_READBACK_EN
  localparam int c_rb_extra = 5;
`else
  localparam int c_rb_extra = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       req_relock = 1'b0;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic       resp_error;
  logic       busy;
  logic       locked;
  logic       pll_lock = 1'b0;
  logic       pll_rst;
  logic [1:0] md_opc;
  logic [7:0] md_wdi;
  logic [7:0] md_rdo = 8'h00;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pll_reconfig_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .RETRY_MAX    (RETRY_MAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_relock (req_relock),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .busy       (busy),
    .locked     (locked),
    .pll_lock   (pll_lock),
    .pll_rst    (pll_rst),
    .md_opc     (md_opc),
    .md_wdi     (md_wdi),
    .md_rdo     (md_rdo)
  );

  // MD register file model: read data appears two cycles after the read opcode.
  logic [7:0] mem [0:255];
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_d1 = 8'h00;
  logic       corrupt = 1'b0;

  always @(posedge clk) begin
    if (md_opc == 2'b11) m_addr <= md_wdi;
    if (md_opc == 2'b01) mem[m_addr] <= md_wdi;
    m_d1  <= mem[m_addr] ^ {7'd0, corrupt};
    md_rdo <= m_d1;
  end

  int   rv_cnt = 0;
  int   rst_pulses = 0;
  int   rst_hi = 0;
  logic prev_rst = 1'b1;

  always @(posedge clk) begin
    #1;
    if (resp_valid) rv_cnt++;
    if (pll_rst && !prev_rst) rst_pulses++;
    if (pll_rst) rst_hi++;
    prev_rst = pll_rst;
  end

  logic [1:0] tr_opc [0:15];
  logic [7:0] tr_wdi [0:15];
  logic       tr_err [0:15];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge showing resp_valid.
  task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input logic rl, input int bound, output int lat);
    req_write  = wr;
    req_addr   = a;
    req_wdata  = d;
    req_relock = rl;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < bound) begin
      if (lat < 16) begin
        tr_opc[lat] = md_opc;
        tr_wdi[lat] = md_wdi;
        tr_err[lat] = resp_error;
      end
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) check_eq("resp_timeout", {31'd0, resp_valid}, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_pll_rst"}, {31'd0, pll_rst}, 32'd1);
    check_eq({tag, "_opc"}, {30'd0, md_opc}, 32'd0);
    check_eq({tag, "_wdi"}, {24'd0, md_wdi}, 32'd0);
    check_eq({tag, "_ready_busy"}, {30'd0, req_ready, busy}, 32'd0);
    check_eq({tag, "_resp"}, {23'd0, resp_valid, resp_error, resp_rdata}, 32'd0);
    check_eq({tag, "_locked"}, {31'd0, locked}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lat, p0, h0, r0;

    // 1: power-up sequence
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;
    n = 0;
    while (pll_rst && n < 50) begin n++; @(negedge clk); end
    check_eq("pwrup_rst_len", n, RST_CYCLES);
    repeat (5) @(negedge clk);
    pll_lock = 1'b1;
    n = 0;
    while (!locked && n < 50) begin @(negedge clk); n++; end
    check_eq("pwrup_lock_delay", n, 3);
    check_eq("pwrup_no_resp", rv_cnt, 0);
    check_eq("pwrup_idle", {30'd0, req_ready, busy}, 32'b10);

    // 2: plain write
    issue(1'b1, 8'h12, 8'h5A, 1'b0, 40, lat);
    check_eq("wr_latency", lat, 5 + c_rb_extra);
    check_eq("wr_opc1", {22'd0, tr_opc[1], tr_wdi[1]}, {22'd0, 2'b11, 8'h12});
    check_eq("wr_opc2", {30'd0, tr_opc[2]}, 32'd0);
    check_eq("wr_opc3", {22'd0, tr_opc[3], tr_wdi[3]}, {22'd0, 2'b01, 8'h5A});
    check_eq("wr_opc4", {30'd0, tr_opc[4]}, 32'd0);
    check_eq("wr_err", {31'd0, resp_error}, 32'd0);
    @(negedge clk);
    check_eq("wr_pulse_one_cycle", {30'd0, resp_valid, busy}, 32'd0);

    // 3: write 0xC3 to 0x08 then read it back
    issue(1'b1, 8'h08, 8'hC3, 1'b0, 40, lat);
    @(negedge clk);
    issue(1'b0, 8'h08, 8'h00, 1'b0, 40, lat);
    check_eq("rd_latency", lat, 6);
    check_eq("rd_opc1", {22'd0, tr_opc[1], tr_wdi[1]}, {22'd0, 2'b11, 8'h08});
    check_eq("rd_opc3", {30'd0, tr_opc[3]}, {30'd0, 2'b10});
    check_eq("rd_data", {23'd0, resp_error, resp_rdata}, {23'd0, 1'b0, 8'hC3});
    @(negedge clk);
    issue(1'b1, 8'h09, 8'h11, 1'b0, 40, lat);
    check_eq("rd_data_holds", {24'd0, resp_rdata}, {24'd0, 8'hC3});

    // 4: lock lost while idle, then relock write that never locks
    @(negedge clk);
    pll_lock = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("lock_drop_idle", {29'd0, locked, busy, pll_rst}, 32'd0);
    p0 = rst_pulses;
    h0 = rst_hi;
    issue(1'b1, 8'h30, 8'hA5, 1'b1, 200, lat);
    check_eq("relock_to_latency", lat, 5 + c_rb_extra + (RETRY_MAX + 1) * (RST_CYCLES + LOCK_TIMEOUT));
    check_eq("relock_to_pulses", rst_pulses - p0, RETRY_MAX + 1);
    check_eq("relock_to_rst_cycles", rst_hi - h0, (RETRY_MAX + 1) * RST_CYCLES);
    check_eq("relock_to_err", {31'd0, resp_error}, 32'd1);
    @(negedge clk);
    check_eq("relock_to_err_clears", {31'd0, resp_error}, 32'd0);

    // 5: async reset during WAIT_LOCK of a relock
    req_write = 1'b1; req_addr = 8'h31; req_wdata = 8'h77; req_relock = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (16) @(negedge clk);
    check_eq("abort_in_wait", {30'd0, busy, pll_rst}, 32'b10);
    r0 = rv_cnt;
    #2 reset = 1'b1;
    #1 check_reset_values("abort");
    @(negedge clk);
    reset = 1'b0;
    pll_lock = 1'b1;
    n = 0;
    while (pll_rst && n < 50) begin n++; @(negedge clk); end
    check_eq("abort_rst_len", n, RST_CYCLES);
    n = 0;
    while (!locked && n < 50) begin @(negedge clk); n++; end
    check_eq("abort_relocked", {31'd0, locked}, 32'd1);
    check_eq("abort_no_resp", rv_cnt - r0, 0);

    // 4b: relock write with lock already present
    p0 = rst_pulses;
    issue(1'b1, 8'h40, 8'h3C, 1'b1, 100, lat);
    check_eq("relock_ok_latency", lat, 5 + c_rb_extra + RST_CYCLES + 1);
    check_eq("relock_ok_pulses", rst_pulses - p0, 1);
    check_eq("relock_ok_err", {31'd0, resp_error}, 32'd0);
    @(negedge clk);
    check_eq("relock_ok_locked", {31'd0, locked}, 32'd1);

    // 6: corrupted readback of a relock write
    corrupt = 1'b1;
    p0 = rst_pulses;
    issue(1'b1, 8'h20, 8'h5A, 1'b1, 100, lat);
    corrupt = 1'b0;
`ifdef PLL_RECONFIG_READBACK_EN
    check_eq("rb_bad_latency", lat, 10);
    check_eq("rb_bad_pulses", rst_pulses - p0, 0);
    check_eq("rb_bad_err", {31'd0, resp_error}, 32'd1);
`else
    check_eq("rb_off_latency", lat, 5 + RST_CYCLES + 1);
    check_eq("rb_off_pulses", rst_pulses - p0, 1);
    check_eq("rb_off_err", {31'd0, resp_error}, 32'd0);
`endif

    // 7: power-up with lock never arriving; error level held until next accept
    @(negedge clk);
    pll_lock = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    r0 = rv_cnt;
    repeat ((RETRY_MAX + 1) * (RST_CYCLES + LOCK_TIMEOUT) + 10) @(negedge clk);
    check_eq("init_err_level", {29'd0, resp_error, req_ready, busy}, 32'b110);
    check_eq("init_err_no_resp", rv_cnt - r0, 0);
    check_eq("init_err_unlocked", {31'd0, locked}, 32'd0);
    issue(1'b0, 8'h08, 8'h00, 1'b0, 40, lat);
    check_eq("init_err_cleared", {31'd0, tr_err[1]}, 32'd0);
    check_eq("init_err_read", {8'd0, lat[7:0], 7'd0, resp_error, resp_rdata}, {8'd0, 8'd6, 8'd0, 8'hC3});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
Sequencer for the PLL dynamic-reconfiguration (MD) port and PLL reset/lock handling.
- Runs the power-up reset/lock sequence.
- Accepts single register read/write requests from one requester (e.g. a video-mode or clock-select register block).
- Issues each request as a timed address/data opcode sequence on the MD port.
- Optionally re-locks the PLL after a write.
- Sits between the PLL wrapper's MD pins and the system bus side, clocked by the MD clock.

Parameters:
RST_CYCLES, 8, cycles pll_rst is held high per reset pulse (min 1)
LOCK_TIMEOUT, 1024, cycles to wait for synced lock after reset release before retry
RETRY_MAX, 3, reset retries after a timeout before declaring error (0 = no retry)

Ports:
clk  in  1  MD clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; transfer on req_valid&req_ready
req_write  in  1  1=write, 0=read
req_addr  in  8  MD register address
req_wdata  in  8  write data
req_relock  in  1  write only: run reset/lock sequence after the data op
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  8  read data; holds until next read completes
resp_error  out  1  valid with resp_valid; lock timeout exhausted (or readback mismatch, see feature)
busy  out  1  ~IDLE
locked  out  1  synced PLL lock AND state is IDLE
pll_lock  in  1  raw PLL lock, asynchronous
pll_rst  out  1  PLL reset
md_opc  out  2  00 nop, 11 load address (md_wdi=addr), 01 write (md_wdi=data), 10 read
md_wdi  out  8  MD write bus
md_rdo  in  8  MD read bus, valid 2 cycles after read opcode

Behaviour:
- Reset values:
  - pll_rst=1.
  - All other outputs 0, with md_opc=00 and md_wdi=0.
  - State INIT_RST, counters 0, retry count 0.
- Lock sync: pll_lock passes through a 2-flop synchronizer (lock_s). All lock decisions use lock_s.
- States:
  - INIT_RST / RST: pll_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK.
  - WAIT_LOCK: pll_rst=0; counter increments each cycle.
    - lock_s=1 → DONE (or IDLE if entered from INIT_RST, no resp_valid).
    - Counter reaches LOCK_TIMEOUT → if retries<RETRY_MAX: retries+1, go to RST; else go to DONE with error=1.
    - Error from INIT_RST: go to IDLE, assert resp_error level-high until next accepted request; no resp_valid.
  - IDLE: req_ready=1. On accept, latch all req_* fields, clear retries, go to ADDR.
  - ADDR (1 cycle): md_opc=11, md_wdi=addr.
  - GAP1 (1 cycle): md_opc=00.
  - OP (1 cycle): write → md_opc=01, md_wdi=wdata; read → md_opc=10.
  - GAP2 (1 cycle): md_opc=00.
  - After GAP2:
    - Read → CAPTURE: resp_rdata<=md_rdo, then DONE.
    - Write with relock → RST.
    - Write without relock → DONE.
  - DONE (1 cycle): resp_valid=1, resp_error per sequence; then IDLE.
- Latency, accept cycle to resp_valid:
  - Write without relock: 5 cycles.
  - Read: 6 cycles.
  - Write with relock: 5+RST_CYCLES+lock wait.
- md_wdi holds its last value when md_opc=00; the MD side ignores it.
- req_valid outside IDLE is ignored. Requester holds until ready; no queueing.
- lock_s dropping while IDLE: locked falls; no automatic relock.
- Async reset mid-operation: immediate return to reset values, full power-up sequence restarts; pending request is lost, no resp.
- Counters sized $clog2(max+1); no wrap, they saturate at the compare value.

Optional Feature:
Macro PLL_RECONFIG_READBACK_EN.
- Defined: after the write data op (before relock), insert ADDR/GAP1/OP(read)/GAP2/CAPTURE for the same address.
  - Mismatch with wdata → skip relock, DONE with resp_error=1.
  - Write latency without relock becomes 10 cycles.
- Undefined: no readback; resp_error only from lock timeout.

Decomposition:
- Package pll_reconfig_pkg: state enum, MD opcode constants (MD_NOP, MD_ADDR, MD_WR, MD_RD).
- One sub-module pll_lock_sync: 2-flop synchronizer, async-reset to 0.

Test Plan:
1. Power-up: params (4,16,2), pll_lock rises 5 cycles after pll_rst falls → pll_rst high 4 cycles, locked=1 two sync cycles after, no resp_valid.
2. Write addr=0x12 data=0x5A, relock=0 → md_opc sequence 11(wdi 0x12),00,01(wdi 0x5A),00; resp_valid 5 cycles after accept, error=0.
3. Read addr=0x08, model returns 0xC3 two cycles after opc=10 → resp_rdata=0xC3, resp_valid 6 cycles after accept.
4. Write with relock, pll_lock never rises, RETRY_MAX=2 → three 4-cycle reset pulses, each followed by 16-cycle wait; then resp_valid with resp_error=1.
5. Assert reset during WAIT_LOCK of a relock → outputs return to reset values at once, pll_rst=1, power-up sequence reruns, no resp_valid.
6. With PLL_RECONFIG_READBACK_EN, model corrupts readback (writes 0x5A, returns 0x5B) → no pll_rst pulse, resp_valid with resp_error=1 at 10 cycles.
